// File: rtl/vedic_pkg.sv
// Shared constants and elaboration helpers for the pipelined Vedic multiplier.
package vedic_pkg;

  localparam int VEDIC_PIPE_STAGES = 3;

  // Legal operand widths: powers of two from 8 to 64.
  function automatic bit vedic_width_ok(input int w);
    return (w >= 8) && (w <= 64) && ((w & (w - 1)) == 0);
  endfunction

  function automatic int vedic_prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/vedic_core.sv
// Combinational W x W Vedic multiplier, built recursively down to 2x2 cells.
module vedic_core #(
  parameter int W = 8
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  if (W == 2) begin : g_cell
    logic c;
    assign c      = (a_i[1] & b_i[0]) & (a_i[0] & b_i[1]);
    assign p_o[0] = a_i[0] & b_i[0];
    assign p_o[1] = (a_i[1] & b_i[0]) ^ (a_i[0] & b_i[1]);
    assign p_o[2] = (a_i[1] & b_i[1]) ^ c;
    assign p_o[3] = (a_i[1] & b_i[1]) & c;
  end else begin : g_rec
    localparam int HW = W / 2;
    logic [3:0][W-1:0] q;

    // q[i]: a half selected by i[0], b half by i[1]
    for (genvar i = 0; i < 4; i++) begin : g_sub
      vedic_core #(.W(HW)) u_sub (
        .a_i(a_i[(i % 2)*HW +: HW]),
        .b_i(b_i[(i / 2)*HW +: HW]),
        .p_o(q[i])
      );
    end

    assign p_o = {q[3], q[0]}
               + {{HW{1'b0}}, q[1], {HW{1'b0}}}
               + {{HW{1'b0}}, q[2], {HW{1'b0}}};
  end

endmodule

// File: rtl/vedic_mult_pipe.sv
// Three-stage pipelined Vedic multiplier with valid/ready on both sides and a tag.
// Define VEDIC_SIGNED_EN to add the in_signed port and two's-complement operation.
module vedic_mult_pipe
  import vedic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_a,
  input  logic [WIDTH-1:0]               in_b,
  input  logic [TAG_W-1:0]               in_tag,
`ifdef VEDIC_SIGNED_EN
  input  logic                           in_signed,
`endif
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [vedic_prod_w(WIDTH)-1:0] out_p,
  output logic [TAG_W-1:0]               out_tag
);

  localparam int H  = WIDTH / 2;
  localparam int PW = vedic_prod_w(WIDTH);
  localparam int NS = VEDIC_PIPE_STAGES;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [WIDTH+1:0] cross_t;

  if (!vedic_width_ok(WIDTH)) begin : g_bad_width
    $fatal(1, "vedic_mult_pipe: WIDTH must be a power of two in 8..64");
  end

  // Bubble-collapsing flow control: a stage loads whenever it is empty or downstream moves.
  logic [NS:1] vld_q, vld_up, rdy, ld;
  assign vld_up = {vld_q[NS-1:1], in_valid};
  assign rdy[3] = !vld_q[3] || out_ready;
  assign rdy[2] = !vld_q[2] || rdy[3];
  assign rdy[1] = !vld_q[1] || rdy[2];
  assign ld     = rdy & vld_up;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else for (int k = 1; k <= NS; k++) if (rdy[k]) vld_q[k] <= vld_up[k];
  end

  word_t a_m, b_m;
`ifdef VEDIC_SIGNED_EN
  logic neg_a, neg_b, sgn1_q, sgn2_q, sgn3_d;
  assign neg_a = in_signed & in_a[WIDTH-1];
  assign neg_b = in_signed & in_b[WIDTH-1];
  assign a_m   = neg_a ? word_t'(-in_a) : in_a;
  assign b_m   = neg_b ? word_t'(-in_b) : in_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn1_q <= 1'b0;
      sgn2_q <= 1'b0;
    end else begin
      if (ld[1]) sgn1_q <= neg_a ^ neg_b;
      if (ld[2]) sgn2_q <= sgn1_q;
    end
  end
  assign sgn3_d = sgn2_q;
`else
  assign a_m = in_a;
  assign b_m = in_b;
`endif

  // Stage 1: pp[0]=aL*bL, pp[1]=aH*bL, pp[2]=aL*bH, pp[3]=aH*bH
  logic [3:0][WIDTH-1:0] pp_d, pp_q;
  logic [TAG_W-1:0]      tag1_q, tag2_q, tag3_q;

  for (genvar i = 0; i < 4; i++) begin : g_pp
    vedic_core #(.W(H)) u_core (
      .a_i(a_m[(i % 2)*H +: H]),
      .b_i(b_m[(i / 2)*H +: H]),
      .p_o(pp_d[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp_q   <= '0;
      tag1_q <= '0;
    end else if (ld[1]) begin
      pp_q   <= pp_d;
      tag1_q <= in_tag;
    end
  end

  // Stage 2: cross sum carries two extra bits so nothing is lost.
  cross_t       cross_d, cross_q;
  logic [H-1:0] lo_q;
  word_t        hh_q;
  assign cross_d = cross_t'(pp_q[1]) + cross_t'(pp_q[2]) + cross_t'(pp_q[0][WIDTH-1:H]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cross_q <= '0;
      lo_q    <= '0;
      hh_q    <= '0;
      tag2_q  <= '0;
    end else if (ld[2]) begin
      cross_q <= cross_d;
      lo_q    <= pp_q[0][H-1:0];
      hh_q    <= pp_q[3];
      tag2_q  <= tag1_q;
    end
  end

  // Stage 3
  word_t           hi_d;
  logic [PW-1:0]   res_u, res_d, p_q;
  assign hi_d  = hh_q + word_t'(cross_q[WIDTH+1:H]);
  assign res_u = {hi_d, cross_q[H-1:0], lo_q};
`ifdef VEDIC_SIGNED_EN
  assign res_d = sgn3_d ? (PW)'(-res_u) : res_u;
`else
  assign res_d = res_u;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q    <= '0;
      tag3_q <= '0;
    end else if (ld[3]) begin
      p_q    <= res_d;
      tag3_q <= tag2_q;
    end
  end

  assign in_ready  = rdy[1];
  assign out_valid = vld_q[3];
  assign out_p     = p_q;
  assign out_tag   = tag3_q;

endmodule
